// File: rtl/bus_source_arbiter_if.sv
// Request/grant bundle between the control unit's register-out requests and the bus-select arbiter.
interface bus_source_arbiter_if #(
    parameter int N_SRC = 24,
    parameter int SEL_W = 5
) ();
    logic [N_SRC-1:0] req;
    logic             done;
    logic [N_SRC-1:0] gnt;
    logic [SEL_W-1:0] bus_sel;
    logic             bus_busy;
    logic             timeout_err;
    logic [SEL_W-1:0] err_src;

    modport master (
        output req, done,
        input  gnt, bus_sel, bus_busy, timeout_err, err_src
    );

    modport slave (
        input  req, done,
        output gnt, bus_sel, bus_busy, timeout_err, err_src
    );
endinterface

// File: rtl/bus_source_arbiter.sv
// Round-robin arbiter for the internal CPU bus: one source at a time, 5-bit select
// (31 = no driver), one-hot grant, hold-time watchdog with a sticky error flag.
module bus_source_arbiter #(
    parameter int N_SRC   = 24,
    parameter int SEL_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 clr,
    bus_source_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    localparam logic [SEL_W-1:0] NO_SEL   = '1;
    localparam logic [N_SRC-1:0] ONE      = N_SRC'(1);
    localparam logic [7:0]       LAST_CNT = 8'(TIMEOUT - 1);
    localparam logic [SEL_W-1:0] PTR_RST  = SEL_W'(N_SRC - 1);

    state_t           state, state_n;
    logic [N_SRC-1:0] gnt_q, gnt_n;
    logic [SEL_W-1:0] sel_q, sel_n;
    logic             busy_q, busy_n;
    logic             terr_q, terr_n;
    logic [SEL_W-1:0] esrc_q, esrc_n;
    logic [SEL_W-1:0] ptr_q, ptr_n;
    logic [7:0]       cnt_q, cnt_n;

    logic             any_req, owner_req;
    logic [SEL_W-1:0] win, hi_win, lo_win, j;
    logic             hi_found;

    // Lowest set index above ptr wins; if none, wrap to the lowest set index overall.
    always_comb begin
        hi_win   = '0;
        lo_win   = '0;
        hi_found = 1'b0;
        j        = '0;
        for (int unsigned i = N_SRC; i > 0; i--) begin
            j = SEL_W'(i - 1);
            if (bus.req[j]) begin
                lo_win = j;
                if (j > ptr_q) begin
                    hi_win   = j;
                    hi_found = 1'b1;
                end
            end
        end
        win = hi_found ? hi_win : lo_win;
    end

    assign any_req   = |bus.req;
    assign owner_req = |(bus.req & gnt_q);

    always_comb begin
        state_n = state;
        gnt_n   = gnt_q;
        sel_n   = sel_q;
        busy_n  = busy_q;
        terr_n  = terr_q;
        esrc_n  = esrc_q;
        ptr_n   = ptr_q;
        cnt_n   = cnt_q;
        case (state)
            IDLE, RELEASE: begin
                if (any_req) begin
                    state_n = GRANT;
                    gnt_n   = ONE << win;
                    sel_n   = win;
                    busy_n  = 1'b1;
                    ptr_n   = win;
                    cnt_n   = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            GRANT: begin
                if (bus.done || !owner_req || cnt_q == LAST_CNT) begin
                    state_n = RELEASE;
                    gnt_n   = '0;
                    sel_n   = NO_SEL;
                    busy_n  = 1'b0;
                    cnt_n   = '0;
                    // Only a genuine expiry flags an error; done or a dropped request take precedence.
                    if (!bus.done && owner_req) begin
                        terr_n = 1'b1;
                        esrc_n = sel_q;
                    end
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            gnt_q  <= '0;
            sel_q  <= NO_SEL;
            busy_q <= 1'b0;
            terr_q <= 1'b0;
            esrc_q <= NO_SEL;
            ptr_q  <= PTR_RST;
            cnt_q  <= '0;
        end else begin
            state  <= state_n;
            gnt_q  <= gnt_n;
            sel_q  <= sel_n;
            busy_q <= busy_n;
            terr_q <= terr_n;
            esrc_q <= esrc_n;
            ptr_q  <= ptr_n;
            cnt_q  <= cnt_n;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.bus_sel     = sel_q;
    assign bus.bus_busy    = busy_q;
    assign bus.timeout_err = terr_q;
    assign bus.err_src     = esrc_q;
endmodule

// File: tb/tb_bus_source_arbiter.sv
// Directed bench for bus_source_arbiter: reset, single grant, round-robin, timeout, abort/tie, clr mid-grant.
module tb_bus_source_arbiter;
    localparam int N_SRC   = 24;
    localparam int SEL_W   = 5;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    bus_source_arbiter_if #(.N_SRC(N_SRC), .SEL_W(SEL_W)) bif ();

    bus_source_arbiter #(.N_SRC(N_SRC), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "bench time limit expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        bif.req  = '1;
        bif.done = 1'b0;
        clr      = 1'b1;
        tick();
        tick();
        n_checks++; if (bif.gnt !== 24'h0) begin n_fail++; $display("FAIL reset_gnt: got %h expected 000000", bif.gnt); end
        n_checks++; if (bif.bus_sel !== 5'd31) begin n_fail++; $display("FAIL reset_sel: got %0d expected 31", bif.bus_sel); end
        n_checks++; if (bif.bus_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bif.bus_busy); end
        n_checks++; if (bif.timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_terr: got %b expected 0", bif.timeout_err); end
        n_checks++; if (bif.err_src !== 5'd31) begin n_fail++; $display("FAIL reset_esrc: got %0d expected 31", bif.err_src); end
        clr     = 1'b0;
        bif.req = '0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        bif.req = 24'(1) << 5;
        tick();
        n_checks++; if (bif.gnt !== 24'h000020) begin n_fail++; $display("FAIL single_gnt: got %h expected 000020", bif.gnt); end
        n_checks++; if (bif.bus_sel !== 5'd5) begin n_fail++; $display("FAIL single_sel: got %0d expected 5", bif.bus_sel); end
        n_checks++; if (bif.bus_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", bif.bus_busy); end
        tick();
        tick();
        bif.done = 1'b1;
        tick();
        bif.done = 1'b0;
        n_checks++; if (bif.bus_sel !== 5'd31) begin n_fail++; $display("FAIL single_rel_sel: got %0d expected 31", bif.bus_sel); end
        n_checks++; if (bif.gnt !== 24'h0) begin n_fail++; $display("FAIL single_rel_gnt: got %h expected 000000", bif.gnt); end
        bif.req = '0;
        tick();
        n_checks++; if (bif.bus_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b expected 0", bif.bus_busy); end
        bif.done = 1'b1;
        tick();
        bif.done = 1'b0;
        n_checks++; if (bif.bus_sel !== 5'd31) begin n_fail++; $display("FAIL idle_done_ignored: got %0d expected 31", bif.bus_sel); end
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_sel [7];
        exp_sel = '{5'd3, 5'd31, 5'd7, 5'd31, 5'd20, 5'd31, 5'd3};
        do_reset();
        bif.req = (24'(1) << 3) | (24'(1) << 7) | (24'(1) << 20);
        tick();
        n_checks++; if (bif.bus_sel !== exp_sel[0]) begin n_fail++; $display("FAIL rr_sel[0]: got %0d expected %0d", bif.bus_sel, exp_sel[0]); end
        for (int k = 1; k < 7; k++) begin
            bif.done = (exp_sel[k-1] != 5'd31);
            tick();
            n_checks++;
            if (bif.bus_sel !== exp_sel[k]) begin
                n_fail++;
                $display("FAIL rr_sel[%0d]: got %0d expected %0d", k, bif.bus_sel, exp_sel[k]);
            end
        end
        bif.done = 1'b0;
        n_checks++; if (bif.gnt !== 24'h000008) begin n_fail++; $display("FAIL rr_gnt_wrap: got %h expected 000008", bif.gnt); end
        bif.req = '0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        bif.req = 24'(1) << 9;
        n = 0;
        tick();
        n_checks++; if (bif.timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_early_err: got %b expected 0", bif.timeout_err); end
        while (bif.bus_busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        n_checks++; if (n !== TIMEOUT) begin n_fail++; $display("FAIL to_busy_cycles: got %0d expected %0d", n, TIMEOUT); end
        n_checks++; if (bif.timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b expected 1", bif.timeout_err); end
        n_checks++; if (bif.err_src !== 5'd9) begin n_fail++; $display("FAIL to_esrc: got %0d expected 9", bif.err_src); end
        n_checks++; if (bif.bus_sel !== 5'd31) begin n_fail++; $display("FAIL to_sel: got %0d expected 31", bif.bus_sel); end
        bif.req = '0;
        tick();
        tick();
        n_checks++; if (bif.timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b expected 1", bif.timeout_err); end
    endtask

    task automatic test_abort_tie();
        do_reset();
        bif.req = 24'(1) << 2;
        tick();
        n_checks++; if (bif.bus_sel !== 5'd2) begin n_fail++; $display("FAIL abort_grant: got %0d expected 2", bif.bus_sel); end
        tick();
        bif.req = '0;
        tick();
        n_checks++; if (bif.bus_sel !== 5'd31) begin n_fail++; $display("FAIL abort_sel: got %0d expected 31", bif.bus_sel); end
        n_checks++; if (bif.timeout_err !== 1'b0) begin n_fail++; $display("FAIL abort_err: got %b expected 0", bif.timeout_err); end
        tick();
        do_reset();
        bif.req = 24'(1) << 4;
        tick();
        for (int k = 0; k < TIMEOUT - 1; k++) tick();
        n_checks++; if (bif.bus_busy !== 1'b1) begin n_fail++; $display("FAIL tie_still_busy: got %b expected 1", bif.bus_busy); end
        bif.done = 1'b1;
        tick();
        bif.done = 1'b0;
        n_checks++; if (bif.bus_sel !== 5'd31) begin n_fail++; $display("FAIL tie_sel: got %0d expected 31", bif.bus_sel); end
        n_checks++; if (bif.timeout_err !== 1'b0) begin n_fail++; $display("FAIL tie_err: got %b expected 0", bif.timeout_err); end
        bif.req = '0;
        tick();
    endtask

    task automatic test_clr_mid_grant();
        do_reset();
        bif.req = 24'(1) << 12;
        tick();
        n_checks++; if (bif.bus_sel !== 5'd12) begin n_fail++; $display("FAIL clr_pre_sel: got %0d expected 12", bif.bus_sel); end
        bif.req = (24'(1) << 12) | 24'(1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++; if (bif.bus_sel !== 5'd31) begin n_fail++; $display("FAIL clr_sel: got %0d expected 31", bif.bus_sel); end
        n_checks++; if (bif.gnt !== 24'h0) begin n_fail++; $display("FAIL clr_gnt: got %h expected 000000", bif.gnt); end
        tick();
        n_checks++; if (bif.bus_sel !== 5'd0) begin n_fail++; $display("FAIL clr_next_sel: got %0d expected 0", bif.bus_sel); end
        n_checks++; if (bif.gnt !== 24'h000001) begin n_fail++; $display("FAIL clr_next_gnt: got %h expected 000001", bif.gnt); end
        bif.req = '0;
        tick();
    endtask

    initial begin
        bif.req  = '0;
        bif.done = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_abort_tie();
        test_clr_mid_grant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
